adder_pipe_param: RTL and testbench
===================================

Name: adder_pipe_param

Overview:
- Parametrised successor to the team's fixed 8-bit, 4-stage pipelined adder.
- Adds two WIDTH-bit operands in STAGES carry-chained slices, one slice per pipeline stage.
- Adds over the fixed block: a subtract mode, a signed-overflow flag, and a valid/ready handshake with backpressure stall.
- Sits between operand producers and consumers in datapath blocks that need wide adds at high clock rates.

Parameters:
- WIDTH, 32, operand and sum width in bits; must be a multiple of STAGES.
- STAGES, 4, number of pipeline stages and of adder slices; range 1..WIDTH.
- CHUNK, WIDTH/STAGES, slice width (localparam, not overridable).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  the operand beat is valid.
- in_ready  output  1  the block accepts a beat this cycle.
- ain  input  WIDTH  operand A.
- bin  input  WIDTH  operand B.
- cin  input  1  carry in; ignored when sub=1.
- sub  input  1  0: A+B+cin; 1: A-B, computed as A+~B+1.
- out_valid  output  1  the result beat is valid.
- out_ready  input  1  the consumer accepts the result.
- sum  output  WIDTH  result, modulo 2^WIDTH.
- cout  output  1  carry out of the MSB; for sub, 1 means no borrow (A>=B unsigned).
- ovf  output  1  two's-complement signed overflow of the operation.

Behaviour:
- Reset (rst=1, asynchronous): all stage valid bits clear, so out_valid=0. sum=0, cout=0, ovf=0. Data registers may also clear.
- in_ready is 1 during reset deassertion handling, as defined by the advance rule below.
- Advance rule: advance = !out_valid | out_ready. in_ready = advance (combinational).
- Stall behaviour: the whole pipeline moves together when advance=1 and holds every register when advance=0. There is no bubble collapsing.
- Accept: a beat is captured into stage 1 when in_valid & in_ready.
- Bubble insertion: when advance=1 and in_valid=0, stage 1 loads valid=0.
- Stage k (k=1..STAGES):
  - Adds slice k-1 of A and B_eff, where B_eff = sub ? ~B : B, plus the carry from stage k-1.
  - Stage 1 carry-in is sub ? 1 : cin.
  - Stores the finished low slices, the carry, and the not-yet-added upper slices of A and B_eff.
  - Input skew: operand slices travel forward in registers until they are consumed.
- Final stage: registers sum, cout and ovf, with ovf = (A[msb] == B_eff[msb]) & (sum[msb] != A[msb]).
- Latency: a beat accepted at edge N appears with out_valid=1 after edge N+STAGES-1, if no stall occurs. Each stall cycle adds one cycle.
- Throughput: one beat per cycle while out_ready=1.
- Output stability: while out_valid=1 & out_ready=0, sum, cout and ovf stay stable and in_ready=0.
- Simultaneous accept and retire: in the same cycle the pipeline shifts and both transfers complete.
- Reset mid-operation: all in-flight beats are discarded and there is no spurious out_valid afterward. After deassertion, the first accepted beat obeys the latency rule.
- STAGES=1 degenerates to a single registered adder with latency 1 and the same handshake.
- Carry chain per stage is CHUNK bits; no stage combines more than one slice's carry chain.

Decomposition:
- Package adder_pipe_pkg holds:
  - A function to check that WIDTH % STAGES == 0. An elaboration-time assertion in the top uses it.
  - Mode constants MODE_ADD=0 and MODE_SUB=1.
- Sub-module adder_pipe_stage:
  - CHUNK-bit slice adder plus the stage register.
  - Ports: clk, rst, en, valid in/out, carry in/out, slice sum.
  - The top instantiates it STAGES times in a generate loop, with the operand skew registers kept in the top.

Test Plan:
- Add, WIDTH=8, STAGES=4, out_ready=1: A=8'hFF, B=8'h01, cin=0, sub=0 -> out_valid exactly 4 edges after accept, sum=8'h00, cout=1, ovf=0.
- Signed overflow, WIDTH=8: A=8'h7F, B=8'h01, sub=0 -> sum=8'h80, cout=0, ovf=1. Then sub=1 with A=8'h80, B=8'h01 -> sum=8'h7F, cout=1, ovf=1.
- Borrow, WIDTH=8: sub=1, A=8'h05, B=8'h07, cin=1 -> sum=8'hFE, cout=0, ovf=0 (cin ignored).
- Backpressure, WIDTH=32, STAGES=4: stream 10 beats A=i, B=2*i (i=0..9). Hold out_ready=0 for 3 cycles after the first result appears -> in_ready=0 during the stall, the held result is stable, and all 10 results 3*i arrive in order with none lost or duplicated.
- Reset mid-flight: accept 3 beats, assert rst for 1 cycle before any result appears -> out_valid stays 0. A new beat A=1, B=1 then returns sum=2 after 4 edges.
- Random sweep over WIDTH 8/16/64 and STAGES 1/2/8 with random out_ready -> every result matches a reference model of {cout,sum} = A + B_eff + carry-in, and ovf matches the signed-overflow rule.

Source files
------------

// File: rtl/adder_pipe_pkg.sv
// Shared definitions for the parametrised pipelined adder: operation mode
// encodings and the parameter sanity check used at elaboration.
package adder_pipe_pkg;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  // True when the operand splits into equal, non-empty slices, one per stage.
  function automatic bit isValidSplit(input int width, input int stages);
    return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/adder_pipe_stage.sv
// One pipeline stage of the adder: a CHUNK-bit slice adder feeding its
// stage register (valid, carry, slice sum and slice-level signed overflow).
module adder_pipe_stage #(
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic             i_valid,
  input  logic             i_carry,
  input  logic [CHUNK-1:0] i_a,
  input  logic [CHUNK-1:0] i_b,
  output logic             o_valid,
  output logic             o_carry,
  output logic             o_ovf,
  output logic [CHUNK-1:0] o_sum
);

  logic [CHUNK:0]   w_add;
  logic             r_valid;
  logic             r_carry;
  logic             r_ovf;
  logic [CHUNK-1:0] r_sum;

  assign w_add = {1'b0, i_a} + {1'b0, i_b} + {{CHUNK{1'b0}}, i_carry};

  // Overflow is only meaningful in the stage holding the operand MSBs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_carry <= 1'b0;
      r_ovf   <= 1'b0;
      r_sum   <= '0;
    end else if (i_en) begin
      r_valid <= i_valid;
      r_carry <= w_add[CHUNK];
      r_ovf   <= (i_a[CHUNK-1] == i_b[CHUNK-1]) & (w_add[CHUNK-1] != i_a[CHUNK-1]);
      r_sum   <= w_add[CHUNK-1:0];
    end
  end

  assign o_valid = r_valid;
  assign o_carry = r_carry;
  assign o_ovf   = r_ovf;
  assign o_sum   = r_sum;

endmodule

// File: rtl/adder_pipe_param.sv
// Parametrised pipelined adder/subtractor: WIDTH-bit operands added in STAGES
// carry-chained slices with a valid/ready handshake and whole-pipe stall.
module adder_pipe_param
  import adder_pipe_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] ain,
  input  logic [WIDTH-1:0] bin,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CHUNK = WIDTH / STAGES;

  if (!isValidSplit(WIDTH, STAGES)) begin : g_paramCheck
    $error("adder_pipe_param: WIDTH (%0d) must be a positive multiple of STAGES (%0d)",
           WIDTH, STAGES);
  end

  logic             w_advance;
  logic [WIDTH-1:0] w_bEff;
  logic             w_carry0;

  logic [CHUNK-1:0] w_aSlice [STAGES];
  logic [CHUNK-1:0] w_bSlice [STAGES];
  logic [CHUNK-1:0] w_aIn    [STAGES];
  logic [CHUNK-1:0] w_bIn    [STAGES];
  logic             w_cIn    [STAGES];
  logic             w_vIn    [STAGES];
  logic             w_vOut   [STAGES];
  logic             w_cOut   [STAGES];
  logic             w_ovf    [STAGES];
  logic [CHUNK-1:0] w_sum    [STAGES];

  // Row k holds what leaves stage k: operand slices above k still waiting
  // for their adder, and finished sum slices below k travelling to the output.
  logic [CHUNK-1:0] r_aSkew   [STAGES][STAGES];
  logic [CHUNK-1:0] r_bSkew   [STAGES][STAGES];
  logic [CHUNK-1:0] r_sumSkew [STAGES][STAGES];

  assign w_advance = !out_valid | out_ready;
  assign in_ready  = w_advance;
  assign w_bEff    = (sub == MODE_SUB) ? ~bin : bin;
  assign w_carry0  = (sub == MODE_SUB) ? 1'b1 : cin;

  for (genvar j = 0; j < STAGES; j++) begin : g_slice
    assign w_aSlice[j] = ain[j*CHUNK +: CHUNK];
    assign w_bSlice[j] = w_bEff[j*CHUNK +: CHUNK];
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_first
      assign w_aIn[k] = w_aSlice[0];
      assign w_bIn[k] = w_bSlice[0];
      assign w_cIn[k] = w_carry0;
      assign w_vIn[k] = in_valid;
    end else begin : g_later
      assign w_aIn[k] = r_aSkew[k-1][k];
      assign w_bIn[k] = r_bSkew[k-1][k];
      assign w_cIn[k] = w_cOut[k-1];
      assign w_vIn[k] = w_vOut[k-1];
    end

    adder_pipe_stage #(
      .CHUNK(CHUNK)
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .i_en    (w_advance),
      .i_valid (w_vIn[k]),
      .i_carry (w_cIn[k]),
      .i_a     (w_aIn[k]),
      .i_b     (w_bIn[k]),
      .o_valid (w_vOut[k]),
      .o_carry (w_cOut[k]),
      .o_ovf   (w_ovf[k]),
      .o_sum   (w_sum[k])
    );
  end

  // The skew rows shift together with the stage registers so every slice
  // of a beat stays aligned with that beat's valid bit and carry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        for (int j = 0; j < STAGES; j++) begin
          r_aSkew[k][j]   <= '0;
          r_bSkew[k][j]   <= '0;
          r_sumSkew[k][j] <= '0;
        end
      end
    end else if (w_advance) begin
      for (int j = 1; j < STAGES; j++) begin
        r_aSkew[0][j] <= w_aSlice[j];
        r_bSkew[0][j] <= w_bSlice[j];
      end
      for (int k = 1; k < STAGES; k++) begin
        for (int j = 0; j < STAGES; j++) begin
          if (j > k) begin
            r_aSkew[k][j] <= r_aSkew[k-1][j];
            r_bSkew[k][j] <= r_bSkew[k-1][j];
          end else if (j < k - 1) begin
            r_sumSkew[k][j] <= r_sumSkew[k-1][j];
          end else if (j == k - 1) begin
            r_sumSkew[k][j] <= w_sum[k-1];
          end
        end
      end
    end
  end

  for (genvar j = 0; j < STAGES; j++) begin : g_sumOut
    if (j == STAGES - 1) begin : g_top
      assign sum[j*CHUNK +: CHUNK] = w_sum[STAGES-1];
    end else begin : g_low
      assign sum[j*CHUNK +: CHUNK] = r_sumSkew[STAGES-1][j];
    end
  end

  assign out_valid = w_vOut[STAGES-1];
  assign cout      = w_cOut[STAGES-1];
  assign ovf       = w_ovf[STAGES-1];

endmodule

// File: tb/tb_adder_pipe_param.sv
// Self-checking bench for adder_pipe_param: directed cases on 8/4 and 32/4
// instances plus randomized scoreboard sweeps over several WIDTH/STAGES pairs.
module tb_adder_pipe_param;

  logic clk;
  int   checks = 0;
  int   errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // ---------------- 8-bit, 4-stage instance for directed cases
  logic       d8Rst, d8InValid, d8InReady, d8Cin, d8Sub;
  logic       d8OutValid, d8OutReady, d8Cout, d8Ovf;
  logic [7:0] d8A, d8B, d8Sum;

  adder_pipe_param #(.WIDTH(8), .STAGES(4)) u_dut8 (
    .clk(clk), .rst(d8Rst), .in_valid(d8InValid), .in_ready(d8InReady),
    .ain(d8A), .bin(d8B), .cin(d8Cin), .sub(d8Sub),
    .out_valid(d8OutValid), .out_ready(d8OutReady),
    .sum(d8Sum), .cout(d8Cout), .ovf(d8Ovf)
  );

  // ---------------- 32-bit, 4-stage instance for the backpressure case
  logic        d32Rst, d32InValid, d32InReady, d32Cin, d32Sub;
  logic        d32OutValid, d32OutReady, d32Cout, d32Ovf;
  logic [31:0] d32A, d32B, d32Sum;

  adder_pipe_param #(.WIDTH(32), .STAGES(4)) u_dut32 (
    .clk(clk), .rst(d32Rst), .in_valid(d32InValid), .in_ready(d32InReady),
    .ain(d32A), .bin(d32B), .cin(d32Cin), .sub(d32Sub),
    .out_valid(d32OutValid), .out_ready(d32OutReady),
    .sum(d32Sum), .cout(d32Cout), .ovf(d32Ovf)
  );

  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b,
                               input logic c, input logic s);
    @(negedge clk);
    d8A = a; d8B = b; d8Cin = c; d8Sub = s; d8InValid = 1'b1;
  endtask

  // Accepting edge counts as edge 1; the result must show after edge 4.
  task automatic runBeat8(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic c, input logic s, input logic [7:0] expSum,
                          input logic expCout, input logic expOvf);
    applyStimulus(a, b, c, s);
    for (int e = 1; e <= 4; e++) begin
      @(posedge clk);
      @(negedge clk);
      if (e == 1) d8InValid = 1'b0;
      if (e >= 3) checkOutput($sformatf("%s_valid_e%0d", tag, e), d8OutValid, (e == 4));
    end
    checkOutput({tag, "_sum"}, d8Sum, expSum);
    checkOutput({tag, "_cout"}, d8Cout, expCout);
    checkOutput({tag, "_ovf"}, d8Ovf, expOvf);
  endtask

  task automatic resetMidFlight();
    logic sawValid;
    sawValid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(8'(i + 3), 8'(i), 1'b0, 1'b0);
      @(posedge clk);
    end
    @(negedge clk);
    d8InValid = 1'b0;
    d8Rst = 1'b1;
    #1;
    checkOutput("midrst_valid", d8OutValid, 0);
    checkOutput("midrst_outputs", {d8Sum, d8Cout, d8Ovf}, 0);
    @(negedge clk);
    d8Rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      sawValid = sawValid | d8OutValid;
    end
    checkOutput("midrst_no_spurious", sawValid, 0);
    runBeat8("midrst_after", 8'd1, 8'd1, 1'b0, 1'b0, 8'd2, 1'b0, 1'b0);
  endtask

  task automatic backpressure32();
    int   sent;
    int   got;
    int   stallLeft;
    logic firstSeen;
    logic sawValid;
    sent = 0; got = 0; stallLeft = 0; firstSeen = 1'b0; sawValid = 1'b0;
    for (int cyc = 0; cyc < 80 && got < 10; cyc++) begin
      @(negedge clk);
      if (d32OutValid && !firstSeen) begin
        firstSeen = 1'b1;
        stallLeft = 3;
      end
      d32OutReady = (stallLeft == 0);
      if (stallLeft > 0) stallLeft--;
      d32InValid = (sent < 10);
      d32A = 32'(sent);
      d32B = 32'(2 * sent);
      d32Cin = 1'b0;
      d32Sub = 1'b0;
      #1;
      if (!d32OutReady) begin
        checkOutput("bp_in_ready", d32InReady, 0);
        checkOutput("bp_held_valid", d32OutValid, 1);
        checkOutput("bp_held_sum", d32Sum, 32'(3 * got));
      end
      if (d32InValid && d32InReady) sent++;
      if (d32OutValid && d32OutReady) begin
        checkOutput($sformatf("bp_result%0d", got), {d32Cout, d32Ovf, d32Sum},
                    {2'b00, 32'(3 * got)});
        got++;
      end
    end
    d32InValid = 1'b0;
    checkOutput("bp_all_received", 32'(got), 32'd10);
    checkOutput("bp_all_sent", 32'(sent), 32'd10);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      sawValid = sawValid | d32OutValid;
    end
    checkOutput("bp_no_duplicate", sawValid, 0);
  endtask

  // ---------------- randomized sweeps, one scoreboard per configuration
  function automatic int randWidth(input int g);
    case (g)
      0: return 8;
      1: return 16;
      2: return 64;
      default: return 8;
    endcase
  endfunction

  function automatic int randStages(input int g);
    case (g)
      0: return 1;
      1: return 2;
      default: return 8;
    endcase
  endfunction

  for (genvar g = 0; g < 4; g++) begin : g_rand
    localparam int W = randWidth(g);
    localparam int S = randStages(g);

    logic         rst, inValid, inReady, cin, sub, outValid, outReady, cout, ovf, done;
    logic [W-1:0] a, b, sum;
    logic [W+1:0] expQ [$];

    adder_pipe_param #(.WIDTH(W), .STAGES(S)) u_dut (
      .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(inReady),
      .ain(a), .bin(b), .cin(cin), .sub(sub),
      .out_valid(outValid), .out_ready(outReady),
      .sum(sum), .cout(cout), .ovf(ovf)
    );

    // {ovf, cout, sum} from plain arithmetic: signed overflow means the true
    // signed result falls outside the W-bit two's-complement range.
    function automatic logic [W+1:0] refModel(input logic [W-1:0] x, input logic [W-1:0] y,
                                              input logic c, input logic s);
      logic [W:0]          wide;
      logic signed [W+1:0] sx, sy, sr, maxPos, minNeg;
      logic                v;
      sx     = {{2{x[W-1]}}, x};
      sy     = {{2{y[W-1]}}, y};
      maxPos = {3'b000, {(W-1){1'b1}}};
      minNeg = {3'b111, {(W-1){1'b0}}};
      if (s) begin
        wide    = {1'b0, x} - {1'b0, y};
        wide[W] = (x >= y);
        sr      = sx - sy;
      end else begin
        wide = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
        sr   = sx + sy + {{(W+1){1'b0}}, c};
      end
      v = (sr > maxPos) || (sr < minNeg);
      return {v, wide};
    endfunction

    initial begin
      logic [63:0] rnd;
      done = 1'b0; rst = 1'b1; inValid = 1'b0; a = '0; b = '0;
      cin = 1'b0; sub = 1'b0; outReady = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput($sformatf("rand%0d_reset", g), {outValid, cout, ovf, sum}, 0);
      rst = 1'b0;
      for (int cyc = 0; cyc < 400; cyc++) begin
        @(negedge clk);
        if (cyc < 340) begin
          inValid = ($urandom_range(3) != 0);
          rnd = {$urandom, $urandom};
          a = rnd[W-1:0];
          rnd = {$urandom, $urandom};
          b = rnd[W-1:0];
          if ($urandom_range(7) == 0) a = '1;
          if ($urandom_range(7) == 0) b = '1;
          sub = ($urandom_range(1) != 0);
          cin = ($urandom_range(1) != 0);
          outReady = ($urandom_range(2) != 0);
        end else begin
          inValid = 1'b0;
          outReady = 1'b1;
        end
        #1;
        if (outValid && !outReady)
          checkOutput($sformatf("rand%0d_stall_ready", g), inReady, 0);
        if (outValid && outReady) begin
          if (expQ.size() == 0)
            checkOutput($sformatf("rand%0d_spurious", g), 1, 0);
          else
            checkOutput($sformatf("rand%0d_result", g), {ovf, cout, sum}, expQ.pop_front());
        end
        if (inValid && inReady) expQ.push_back(refModel(a, b, cin, sub));
      end
      checkOutput($sformatf("rand%0d_drained", g), 32'(expQ.size()), 32'd0);
      done = 1'b1;
    end
  end

  // ---------------- main sequence
  initial begin
    d8Rst = 1'b1; d8InValid = 1'b0; d8A = '0; d8B = '0; d8Cin = 1'b0; d8Sub = 1'b0;
    d8OutReady = 1'b0;
    d32Rst = 1'b1; d32InValid = 1'b0; d32A = '0; d32B = '0; d32Cin = 1'b0; d32Sub = 1'b0;
    d32OutReady = 1'b1;
    #1;
    checkOutput("reset_in_ready", d8InReady, 1);
    checkOutput("reset_out_valid", d8OutValid, 0);
    checkOutput("reset_outputs", {d8Sum, d8Cout, d8Ovf}, 0);
    d8OutReady = 1'b1;
    repeat (2) @(negedge clk);
    d8Rst = 1'b0;
    d32Rst = 1'b0;

    runBeat8("add_carry", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    runBeat8("add_ovf", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
    runBeat8("sub_ovf", 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);
    runBeat8("sub_borrow", 8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0);
    resetMidFlight();
    backpressure32();

    wait (g_rand[0].done && g_rand[1].done && g_rand[2].done && g_rand[3].done);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "[TB] timeout");
  end

endmodule
